// File: rtl/dpb_frame_reader_if.sv
// Purpose: groups start/status, RAM port-B and byte-stream signals of dpb_frame_reader.
// Latency: none; this is a wiring bundle only.
// Backpressure: tx_ready (slave -> master) stalls the byte stream.
interface dpb_frame_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_cnt;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_adb;
    logic              ram_ceb;
    logic              ram_oceb;
    logic [DATA_W-1:0] ram_doutb;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;

    // master: the reader engine
    modport master (
        input  start, base_addr, word_cnt, ram_doutb, tx_ready,
        output busy, done, ram_adb, ram_ceb, ram_oceb, tx_data, tx_valid, tx_last
    );

    // slave: controller, RAM port B and byte sink
    modport slave (
        output start, base_addr, word_cnt, ram_doutb, tx_ready,
        input  busy, done, ram_adb, ram_ceb, ram_oceb, tx_data, tx_valid, tx_last
    );
endinterface

// File: rtl/dpb_frame_reader.sv
// Purpose: reads a run of 64-bit words from line-buffer port B and serializes them MSB byte first.
// Latency: first byte 4 cycles after an accepted start (issue, 2-cycle RAM read, shifter load).
// Backpressure: tx_ready low freezes the shifter; reads are only issued when the prefetch slot frees.
module dpb_frame_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 2
) (
    input logic                clk,
    input logic                rst,
    dpb_frame_reader_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_busy;
    logic                w_done;

    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_rd_left;
    logic [ADDR_W:0]     r_tx_left;
    logic [RD_LAT-1:0]   r_inflight;
    logic [DATA_W-1:0]   r_pf;
    logic                r_pf_vld;
    logic [DATA_W-1:0]   r_sh;
    logic                r_sh_vld;
    logic [2:0]          r_sh_idx;

    logic [ADDR_W:0]     w_cnt_clamped;
    logic                w_accept;
    logic                w_xfer;
    logic                w_byte7;
    logic                w_tx_last;
    logic                w_sh_load;
    logic                w_issue;

    assign w_cnt_clamped = (bus.word_cnt > MAX_CNT) ? MAX_CNT : bus.word_cnt;
    assign w_accept      = bus.start && (r_state == S_IDLE);
    assign w_xfer        = r_sh_vld && bus.tx_ready;
    assign w_byte7       = (r_sh_idx == 3'd7);
    assign w_tx_last     = r_sh_vld && w_byte7 && (r_tx_left == (ADDR_W+1)'(1));
    // The shifter takes the prefetched word when empty or when its last byte leaves this cycle.
    assign w_sh_load     = r_pf_vld && (!r_sh_vld || (w_xfer && w_byte7));
    // One read in flight at a time, and only when the prefetch slot is (or is becoming) free.
    assign w_issue       = (r_state == S_RUN) && (r_rd_left != '0) && (r_inflight == '0) &&
                           (!r_pf_vld || w_sh_load);

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.ram_oceb = w_busy;
    assign bus.ram_ceb  = w_issue;
    assign bus.ram_adb  = r_rd_ptr;
    assign bus.tx_valid = r_sh_vld;
    assign bus.tx_data  = r_sh_vld ? r_sh[DATA_W-1 -: 8] : 8'd0;
    assign bus.tx_last  = w_tx_last;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = (w_cnt_clamped == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_xfer && w_tx_last) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                w_busy      = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read bookkeeping, prefetch capture and byte shifter; FLUSH wipes the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_rd_left  <= '0;
            r_tx_left  <= '0;
            r_inflight <= '0;
            r_pf       <= '0;
            r_pf_vld   <= 1'b0;
            r_sh       <= '0;
            r_sh_vld   <= 1'b0;
            r_sh_idx   <= '0;
        end else if (r_state == S_FLUSH) begin
            r_rd_left  <= '0;
            r_tx_left  <= '0;
            r_inflight <= '0;
            r_pf_vld   <= 1'b0;
            r_sh       <= '0;
            r_sh_vld   <= 1'b0;
            r_sh_idx   <= '0;
        end else begin
            if (w_accept && (w_cnt_clamped != '0)) begin
                r_rd_ptr  <= bus.base_addr;
                r_rd_left <= w_cnt_clamped;
                r_tx_left <= w_cnt_clamped;
            end
            if (w_issue) begin
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
                r_rd_left <= r_rd_left - (ADDR_W+1)'(1);
            end
            r_inflight <= (r_inflight << 1) | RD_LAT'(w_issue);

            if (r_inflight[RD_LAT-1]) begin
                r_pf     <= bus.ram_doutb;
                r_pf_vld <= 1'b1;
            end else if (w_sh_load) begin
                r_pf_vld <= 1'b0;
            end

            if (w_sh_load) begin
                r_sh     <= r_pf;
                r_sh_idx <= 3'd0;
                r_sh_vld <= 1'b1;
            end else if (w_xfer) begin
                r_sh     <= r_sh << 8;
                r_sh_idx <= r_sh_idx + 3'd1;
                if (w_byte7) r_sh_vld <= 1'b0;
            end

            if (w_xfer && w_byte7) r_tx_left <= r_tx_left - (ADDR_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_dpb_frame_reader.sv
// Bench for dpb_frame_reader: RAM port-B model, byte/address scoreboards and a negedge monitor.
module tb_dpb_frame_reader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dpb_frame_reader_if bus ();

    dpb_frame_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Pipelined RAM port B: address register on ceb, output register on oceb.
    logic [63:0] mem [0:1023];
    logic [63:0] ram_s1;
    always @(posedge clk) begin
        if (bus.ram_ceb)  ram_s1 <= mem[bus.ram_adb];
        if (bus.ram_oceb) bus.ram_doutb <= ram_s1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] exp_byte [$];
    int         exp_addr [$];
    int total = 0;
    int bad   = 0;
    int n_done = 0, done_cyc = 0, first_cyc = 0, last_cyc = 0, run_bytes = 0, n_ceb = 0;
    int start_cyc = 0;
    bit first_seen = 0;
    bit p_stall = 0;
    logic [7:0] p_data;
    logic       p_last;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops scoreboards on byte transfers and read issues, checks stall stability.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            p_stall = 0;
        end else begin
            if (p_stall) begin
                chk("stall_valid", 64'(bus.tx_valid), 64'd1);
                chk("stall_data", 64'(bus.tx_data), 64'(p_data));
                chk("stall_last", 64'(bus.tx_last), 64'(p_last));
            end
            p_stall = bus.tx_valid && !bus.tx_ready;
            p_data  = bus.tx_data;
            p_last  = bus.tx_last;
            if (bus.tx_valid && !first_seen) begin
                first_seen = 1;
                first_cyc  = cyc;
            end
            if (bus.tx_valid && bus.tx_ready) begin
                run_bytes++;
                last_cyc = cyc;
                if (exp_byte.size() == 0) begin
                    total++; bad++;
                    $display("FAIL byte_unexpected: got %0h expected none", bus.tx_data);
                end else begin
                    e = exp_byte.pop_front();
                    chk("byte_data", 64'(bus.tx_data), 64'(e[7:0]));
                    chk("byte_last", 64'(bus.tx_last), 64'(e[8]));
                end
            end
            if (bus.ram_ceb) begin
                n_ceb++;
                if (exp_addr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ram_unexpected: got addr %0d expected no read", bus.ram_adb);
                end else begin
                    chk("ram_addr", 64'(bus.ram_adb), 64'(exp_addr.pop_front()));
                end
            end
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
                chk("done_busy", 64'(bus.busy), 64'd0);
            end
        end
    end

    task automatic push_words(input int base, input int cnt);
        logic [63:0] w;
        int a;
        for (int i = 0; i < cnt; i++) begin
            a = (base + i) % 1024;
            w = mem[a];
            exp_addr.push_back(a);
            for (int b = 0; b < 8; b++)
                exp_byte.push_back({(i == cnt - 1 && b == 7), w[63 - 8*b -: 8]});
        end
    endtask

    task automatic start_run(input int base, input int cnt);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = 10'(base);
        bus.word_cnt  = 11'(cnt);
        start_cyc  = cyc;
        first_seen = 0;
        run_bytes  = 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int lim);
        int n;
        int d0;
        n  = 0;
        d0 = n_done;
        while (n_done == d0 && n < lim) begin @(posedge clk); n++; end
        chk(nm, 64'(n_done - d0), 64'd1);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_bytes(input string nm, input int nb);
        int k;
        k = 0;
        while (run_bytes < nb && k < 500) begin @(posedge clk); k++; end
        chk(nm, 64'(run_bytes >= nb), 64'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  64'(bus.busy),     64'd0);
        chk({tag, "_done"},  64'(bus.done),     64'd0);
        chk({tag, "_ceb"},   64'(bus.ram_ceb),  64'd0);
        chk({tag, "_oceb"},  64'(bus.ram_oceb), 64'd0);
        chk({tag, "_adb"},   64'(bus.ram_adb),  64'd0);
        chk({tag, "_valid"}, 64'(bus.tx_valid), 64'd0);
        chk({tag, "_data"},  64'(bus.tx_data),  64'd0);
        chk({tag, "_last"},  64'(bus.tx_last),  64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat;
        int k, d0, c0;
        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.word_cnt = '0; bus.tx_ready = 1'b1;
        ram_s1 = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
        for (int i = 0; i < 8; i++)
            mem[i] = 64'h0001020304050607 + 64'h0808080808080808 * 64'(i);
        mem[1022] = 64'hA0A1A2A3A4A5A6A7;
        mem[1023] = 64'hB0B1B2B3B4B5B6B7;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        // Base 0, four words, sink always ready: bytes 0x00..0x1F.
        for (int i = 0; i < 4; i++) exp_addr.push_back(i);
        for (int i = 0; i < 32; i++) exp_byte.push_back({(i == 31), 8'(i)});
        start_run(0, 4);
        wait_done("t1_done", 200);
        chk("t1_first_lat", 64'(first_cyc - start_cyc), 64'd5);
        chk("t1_gapless", 64'(last_cyc - first_cyc), 64'd31);
        chk("t1_done_lat", 64'(done_cyc - last_cyc), 64'd2);
        chk("t1_nbytes", 64'(run_bytes), 64'd32);
        chk("t1_left", 64'(exp_byte.size()), 64'd0);

        // Address wrap 1022 -> 1023 -> 0 -> 1.
        push_words(1022, 4);
        start_run(1022, 4);
        wait_done("t2_done", 200);
        chk("t2_nbytes", 64'(run_bytes), 64'd32);
        chk("t2_addr_left", 64'(exp_addr.size()), 64'd0);

        // Single word with a stalling sink.
        pat = 16'b1001_0110_1001_1101;
        push_words(2, 1);
        start_run(2, 1);
        k = 0; d0 = n_done;
        while (n_done == d0 && k < 300) begin
            @(posedge clk); #1;
            bus.tx_ready = pat[k % 16];
            k++;
        end
        chk("t3_done", 64'(n_done - d0), 64'd1);
        bus.tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        chk("t3_nbytes", 64'(run_bytes), 64'd8);

        // Zero-length run.
        c0 = n_ceb;
        start_run(5, 0);
        wait_done("t4_done", 20);
        chk("t4_done_lat", 64'(done_cyc - start_cyc), 64'd1);
        chk("t4_no_read", 64'(n_ceb - c0), 64'd0);
        chk("t4_no_bytes", 64'(run_bytes), 64'd0);

        // Start pulsed mid-run is ignored.
        push_words(4, 2);
        start_run(4, 2);
        wait_bytes("t5_wait", 3);
        #1;
        bus.start = 1'b1; bus.base_addr = 10'd1022; bus.word_cnt = 11'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        d0 = n_done;
        wait_done("t5_done", 200);
        repeat (10) @(posedge clk);
        chk("t5_one_done", 64'(n_done - d0), 64'd1);
        chk("t5_nbytes", 64'(run_bytes), 64'd16);
        chk("t5_addr_left", 64'(exp_addr.size()), 64'd0);

        // Reset after 10 bytes of an 8-word run, then a clean 2-word run.
        push_words(0, 8);
        start_run(0, 8);
        wait_bytes("t6_wait", 10);
        #1;
        rst = 1'b1;
        exp_byte.delete();
        exp_addr.delete();
        d0 = n_done;
        @(negedge clk);
        chk_idle("t6_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        chk("t6_no_done", 64'(n_done - d0), 64'd0);
        push_words(0, 2);
        start_run(0, 2);
        wait_done("t6_done", 200);
        chk("t6_nbytes", 64'(run_bytes), 64'd16);
        chk("t6_left", 64'(exp_byte.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
